// File: rtl/cdc_status_rx_if.sv
// Status bus between a two-flop synchronizer output and the consumer of
// qualified status words; the receiver sits on the slave modport.
interface cdc_status_rx_if;
  logic [7:0] sync_data_i;
  logic       ready_i;
  logic [7:0] status_o;
  logic       valid_o;
  logic [7:0] update_cnt_o;
  logic [7:0] glitch_cnt_o;

  modport master (
    output sync_data_i, ready_i,
    input  status_o, valid_o, update_cnt_o, glitch_cnt_o
  );

  modport slave (
    input  sync_data_i, ready_i,
    output status_o, valid_o, update_cnt_o, glitch_cnt_o
  );
endinterface

// File: rtl/cdc_status_rx.sv
// Qualifies a multi-bit synchronized status word: a value must be sampled
// unchanged for STABLE_CYCLES edges before it is presented to the consumer.
module cdc_status_rx #(
  parameter int         STABLE_CYCLES = 3,
  parameter logic [7:0] RESET_VAL     = 8'h00
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  cdc_status_rx_if.slave         bus,
  output logic [1:0]             dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PRESENT = 2'd2
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(STABLE_CYCLES - 1);

  state_e     state_q;
  logic [3:0] cnt_q;
  logic [7:0] cand_q;
  logic [7:0] status_q;
  logic       valid_q;
  logic [7:0] update_cnt_q;
  logic [7:0] glitch_cnt_q;

  // Handshake: status_o is transferred on any rising edge where valid_o and
  // ready_i are both high; valid_o and status_o stay frozen until then, and
  // ready_i has no effect while valid_o is low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      cand_q       <= 8'h00;
      status_q     <= RESET_VAL;
      valid_q      <= 1'b0;
      update_cnt_q <= 8'd0;
      glitch_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.sync_data_i != status_q) begin
            state_q <= QUALIFY;
            cand_q  <= bus.sync_data_i;
            cnt_q   <= 4'd1;
          end
        end
        QUALIFY: begin
          if (bus.sync_data_i == cand_q) begin
            if (cnt_q == LAST_CNT) begin
              status_q     <= cand_q;
              valid_q      <= 1'b1;
              update_cnt_q <= update_cnt_q + 8'd1;
              state_q      <= PRESENT;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end else begin
            if (glitch_cnt_q != 8'hFF) glitch_cnt_q <= glitch_cnt_q + 8'd1;
            if (bus.sync_data_i == status_q) begin
              state_q <= IDLE;
            end else begin
              cand_q <= bus.sync_data_i;
              cnt_q  <= 4'd1;
            end
          end
        end
        PRESENT: begin
          // Input changes are ignored here; IDLE re-compares after the handshake.
          if (bus.ready_i) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.status_o     = status_q;
  assign bus.valid_o      = valid_q;
  assign bus.update_cnt_o = update_cnt_q;
  assign bus.glitch_cnt_o = glitch_cnt_q;
  assign dbg_state_o      = state_q;

endmodule
